power_threshold_detect: RTL and testbench

Consumer of the `power_integrate` output stream. It accepts strobed 32-bit power values and compares them against settings-bus-programmed high and low thresholds. A hysteresis/holdoff state machine produces an activity level, a one-cycle event pulse, a saturating event counter and a running peak. It sits directly downstream of `power_integrate` in the RX DSP chain; its outputs feed the readback mux and timed-command/trigger logic.

---
 rtl/power_threshold_detect_if.sv | 21 ++
 rtl/power_threshold_detect.sv | 93 +++++++++
 tb/tb_power_threshold_detect.sv | 230 +++++++++++++++++++++++
 3 files changed

// File: rtl/power_threshold_detect_if.sv
// power_threshold_detect_if: settings bus, power sample stream and detector outputs
interface power_threshold_detect_if;
    logic        set_stb;
    logic [7:0]  set_addr;
    logic [31:0] set_data;
    logic [31:0] power_in;
    logic        strobe_in;
    logic        active;
    logic        event_stb;
    logic [15:0] event_count;
    logic [31:0] peak;
    logic [2:0]  state_out;
    modport master (
        output set_stb, set_addr, set_data, power_in, strobe_in,
        input  active, event_stb, event_count, peak, state_out
    );
    modport slave (
        input  set_stb, set_addr, set_data, power_in, strobe_in,
        output active, event_stb, event_count, peak, state_out
    );
endinterface

// File: rtl/power_threshold_detect.sv
// power_threshold_detect: hysteresis/holdoff threshold detector with event counter and running peak
module power_threshold_detect #(
    parameter int BASE = 0
) (
    input logic                    clk,
    input logic                    reset,
    power_threshold_detect_if.slave bus
);
    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        BELOW   = 3'd1,
        PENDING = 3'd2,
        ACTIVE  = 3'd3,
        HOLDOFF = 3'd4
    } state_t;
    state_t      state, nxt;
    logic [31:0] thr_hi, thr_lo, peak_q;
    logic        enable, act_q, evt_q;
    logic [7:0]  n_assert, cnt, nxt_cnt, cnt_inc, off;
    logic [15:0] holdoff, hcnt, nxt_hcnt, event_cnt;
    logic        above, below, clr, enter;
    assign off     = bus.set_addr - 8'(BASE);
    assign clr     = bus.set_stb && off == 8'd3;
    assign above   = bus.power_in >= thr_hi;
    assign below   = bus.power_in < thr_lo;
    assign cnt_inc = cnt + 8'd1;
    assign enter   = nxt == ACTIVE && state != ACTIVE;
    always_comb begin
        nxt      = state;
        nxt_cnt  = cnt;
        nxt_hcnt = hcnt;
        if (!enable) begin
            nxt      = IDLE;
            nxt_cnt  = 8'd0;
            nxt_hcnt = 16'd0;
        end else if (state == IDLE) begin
            nxt = BELOW;
        end else if (bus.strobe_in) begin
            case (state)
                BELOW: if (above) begin
                    nxt     = n_assert <= 8'd1 ? ACTIVE : PENDING;
                    nxt_cnt = 8'd1;
                end
                PENDING: begin
                    nxt     = !above ? BELOW : cnt_inc == n_assert ? ACTIVE : PENDING;
                    nxt_cnt = above ? cnt_inc : 8'd0;
                end
                ACTIVE: if (below) begin
                    nxt      = holdoff == 16'd0 ? BELOW : HOLDOFF;
                    nxt_hcnt = holdoff;
                end
                HOLDOFF: begin
                    nxt      = hcnt == 16'd1 ? BELOW : HOLDOFF;
                    nxt_hcnt = hcnt - 16'd1;
                end
                default: nxt = IDLE;
            endcase
        end
    end
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            cnt       <= 8'd0;
            hcnt      <= 16'd0;
            thr_hi    <= 32'd0;
            thr_lo    <= 32'd0;
            enable    <= 1'b0;
            n_assert  <= 8'd0;
            holdoff   <= 16'd0;
            event_cnt <= 16'd0;
            peak_q    <= 32'd0;
            act_q     <= 1'b0;
            evt_q     <= 1'b0;
        end else begin
            state     <= nxt;
            cnt       <= nxt_cnt;
            hcnt      <= nxt_hcnt;
            act_q     <= nxt == ACTIVE;
            evt_q     <= enter;
            // a clear in the same cycle as an event or a new maximum takes priority
            event_cnt <= clr ? 16'd0 : (enter && event_cnt != 16'hFFFF) ? event_cnt + 16'd1 : event_cnt;
            peak_q    <= clr ? 32'd0 : (bus.strobe_in && enable && bus.power_in > peak_q) ? bus.power_in : peak_q;
            if (bus.set_stb && off == 8'd0) thr_hi <= bus.set_data;
            if (bus.set_stb && off == 8'd1) thr_lo <= bus.set_data;
            if (bus.set_stb && off == 8'd2) {holdoff, n_assert, enable} <= {bus.set_data[31:16], bus.set_data[15:8], bus.set_data[0]};
        end
    end
    assign bus.active      = act_q;
    assign bus.event_stb   = evt_q;
    assign bus.event_count = event_cnt;
    assign bus.peak        = peak_q;
    assign bus.state_out   = state;
endmodule

// File: tb/tb_power_threshold_detect.sv
// tb_power_threshold_detect: vector table, corner sequences and randomized run against a behavioural model
module tb_power_threshold_detect;
    logic clk = 1'b0;
    logic reset = 1'b1;
    power_threshold_detect_if bus();
    power_threshold_detect #(.BASE(0)) dut (.clk(clk), .reset(reset), .bus(bus));
    always #5 clk = ~clk;

    typedef struct {
        logic        s;
        logic [7:0]  a;
        logic [31:0] d;
        logic        st;
        logic [31:0] p;
        logic [2:0]  e_state;
        logic        e_evt;
        logic [15:0] e_count;
        logic [31:0] e_peak;
    } vec_t;
    vec_t tbl[$];

    int errors = 0;
    int checks = 0;

    logic [31:0] m_thr_hi, m_thr_lo, m_peak;
    logic        m_en, m_evt;
    logic [7:0]  m_n, m_cnt;
    logic [15:0] m_hold, m_hcnt, m_count;
    logic [2:0]  m_st;

    function automatic vec_t v(int s, int a, int d, int st, int p, int es, int ee, int ec, int ep);
        vec_t r;
        r.s = s[0]; r.a = 8'(a); r.d = 32'(d); r.st = st[0]; r.p = 32'(p);
        r.e_state = 3'(es); r.e_evt = ee[0]; r.e_count = 16'(ec); r.e_peak = 32'(ep);
        return r;
    endfunction

    function automatic logic [52:0] dut_vec();
        return {bus.active, bus.event_stb, bus.event_count, bus.peak, bus.state_out};
    endfunction

    function automatic logic [52:0] model_vec();
        return {m_st == 3'd3, m_evt, m_count, m_peak, m_st};
    endfunction

    task automatic chk(input string name, input logic [52:0] got, input logic [52:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got act=%0b evt=%0b cnt=%h peak=%h st=%0d, expected act=%0b evt=%0b cnt=%h peak=%h st=%0d",
                name, got[52], got[51], got[50:35], got[34:3], got[2:0],
                exp[52], exp[51], exp[50:35], exp[34:3], exp[2:0]);
        end
    endtask

    task automatic model_reset();
        m_thr_hi = 0; m_thr_lo = 0; m_peak = 0; m_en = 0; m_evt = 0;
        m_n = 0; m_cnt = 0; m_hold = 0; m_hcnt = 0; m_count = 0; m_st = 0;
    endtask

    task automatic model_step(input logic s, input logic [7:0] a, input logic [31:0] d, input logic st, input logic [31:0] p);
        logic [2:0] old;
        logic clr, above, below;
        old = m_st;
        clr = s && a == 8'd3;
        above = p >= m_thr_hi;
        below = p < m_thr_lo;
        if (!m_en) begin
            m_st = 0; m_cnt = 0; m_hcnt = 0;
        end else if (m_st == 0) begin
            m_st = 1;
        end else if (st) begin
            case (m_st)
                3'd1: if (above) begin
                    if (m_n <= 1) m_st = 3;
                    else begin m_st = 2; m_cnt = 1; end
                end
                3'd2: if (above) begin
                    m_cnt = m_cnt + 8'd1;
                    if (m_cnt == m_n) m_st = 3;
                end else begin
                    m_st = 1; m_cnt = 0;
                end
                3'd3: if (below) begin
                    if (m_hold == 0) m_st = 1;
                    else begin m_st = 4; m_hcnt = m_hold; end
                end
                3'd4: begin
                    m_hcnt = m_hcnt - 16'd1;
                    if (m_hcnt == 0) m_st = 1;
                end
                default: m_st = 0;
            endcase
        end
        m_evt = m_st == 3 && old != 3;
        if (clr) m_peak = 0;
        else if (st && m_en && p > m_peak) m_peak = p;
        if (clr) m_count = 0;
        else if (m_evt && m_count != 16'hFFFF) m_count = m_count + 16'd1;
        if (s && a == 8'd0) m_thr_hi = d;
        if (s && a == 8'd1) m_thr_lo = d;
        if (s && a == 8'd2) begin m_en = d[0]; m_n = d[15:8]; m_hold = d[31:16]; end
    endtask

    task automatic cyc(input logic s, input logic [7:0] a, input logic [31:0] d, input logic st, input logic [31:0] p);
        @(negedge clk);
        reset = 1'b0;
        bus.set_stb = s; bus.set_addr = a; bus.set_data = d; bus.strobe_in = st; bus.power_in = p;
        @(posedge clk);
        model_step(s, a, d, st, p);
        #1;
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        bus.set_stb = 0; bus.set_addr = 0; bus.set_data = 0; bus.strobe_in = 0; bus.power_in = 0;
        @(posedge clk);
        model_reset();
        #1;
    endtask

    initial begin
        logic        s, st;
        logic [7:0]  a;
        logic [31:0] d, p;
        bus.set_stb = 0; bus.set_addr = 0; bus.set_data = 0; bus.strobe_in = 0; bus.power_in = 0;
        model_reset();

        tbl.push_back(v(1, 0, 1000, 0, 0,      0, 0, 0, 0));
        tbl.push_back(v(1, 1, 500, 0, 0,       0, 0, 0, 0));
        tbl.push_back(v(1, 2, 'h101, 0, 0,     0, 0, 0, 0));
        tbl.push_back(v(0, 0, 0, 0, 0,         1, 0, 0, 0));
        tbl.push_back(v(0, 0, 0, 1, 999,       1, 0, 0, 999));
        tbl.push_back(v(0, 0, 0, 1, 1000,      3, 1, 1, 1000));
        tbl.push_back(v(0, 0, 0, 0, 0,         3, 0, 1, 1000));
        tbl.push_back(v(1, 2, 'h20101, 0, 0,   3, 0, 1, 1000));
        tbl.push_back(v(0, 0, 0, 1, 499,       4, 0, 1, 1000));
        tbl.push_back(v(0, 0, 0, 1, 5000,      4, 0, 1, 5000));
        tbl.push_back(v(0, 0, 0, 0, 0,         4, 0, 1, 5000));
        tbl.push_back(v(0, 0, 0, 1, 5000,      1, 0, 1, 5000));
        tbl.push_back(v(0, 0, 0, 1, 5000,      3, 1, 2, 5000));
        tbl.push_back(v(1, 2, 'h101, 0, 0,     3, 0, 2, 5000));
        tbl.push_back(v(0, 0, 0, 1, 700,       3, 0, 2, 5000));
        tbl.push_back(v(0, 0, 0, 1, 499,       1, 0, 2, 5000));
        tbl.push_back(v(1, 2, 'h301, 0, 0,     1, 0, 2, 5000));
        tbl.push_back(v(0, 0, 0, 1, 1200,      2, 0, 2, 5000));
        tbl.push_back(v(0, 0, 0, 1, 1200,      2, 0, 2, 5000));
        tbl.push_back(v(0, 0, 0, 1, 400,       1, 0, 2, 5000));
        tbl.push_back(v(0, 0, 0, 1, 1200,      2, 0, 2, 5000));
        tbl.push_back(v(0, 0, 0, 1, 1200,      2, 0, 2, 5000));
        tbl.push_back(v(0, 0, 0, 1, 1200,      3, 1, 3, 5000));
        tbl.push_back(v(0, 0, 0, 0, 0,         3, 0, 3, 5000));
        tbl.push_back(v(1, 3, 'hdead, 0, 0,    3, 0, 0, 0));
        tbl.push_back(v(0, 0, 0, 1, 10,        1, 0, 0, 10));
        tbl.push_back(v(0, 0, 0, 1, 300,       1, 0, 0, 300));
        tbl.push_back(v(0, 0, 0, 1, 20,        1, 0, 0, 300));
        tbl.push_back(v(0, 0, 0, 1, 2000,      2, 0, 0, 2000));
        tbl.push_back(v(0, 0, 0, 1, 2000,      2, 0, 0, 2000));
        tbl.push_back(v(1, 3, 0, 1, 2000,      3, 1, 0, 0));
        tbl.push_back(v(0, 0, 0, 0, 0,         3, 0, 0, 0));

        do_reset();
        do_reset();
        chk("reset", dut_vec(), 53'd0);

        foreach (tbl[i]) begin
            cyc(tbl[i].s, tbl[i].a, tbl[i].d, tbl[i].st, tbl[i].p);
            chk($sformatf("tbl[%0d]", i), dut_vec(),
                {tbl[i].e_state == 3'd3, tbl[i].e_evt, tbl[i].e_count, tbl[i].e_peak, tbl[i].e_state});
        end

        // Preload the counter near its limit instead of generating ~65k events
        cyc(1, 2, 32'h101, 0, 0);
        chk("sat_setup", dut_vec(), model_vec());
        force dut.event_cnt = 16'hFFFD;
        m_count = 16'hFFFD;
        cyc(0, 0, 0, 0, 0);
        release dut.event_cnt;
        chk("sat_preload", dut_vec(), model_vec());
        for (int k = 0; k < 3; k++) begin
            cyc(0, 0, 0, 1, 100);
            chk($sformatf("sat_below[%0d]", k), dut_vec(), model_vec());
            cyc(0, 0, 0, 1, 6000);
            chk($sformatf("sat_event[%0d]", k), dut_vec(), model_vec());
        end
        chk("sat_final", {15'd0, bus.event_count, 22'd0}, {15'd0, 16'hFFFF, 22'd0});

        cyc(1, 2, 32'h100, 0, 0);
        chk("disable_write", dut_vec(), model_vec());
        cyc(0, 0, 0, 0, 0);
        chk("disable_idle", dut_vec(), model_vec());
        cyc(0, 0, 0, 1, 90000);
        chk("disable_peak0", dut_vec(), model_vec());
        cyc(0, 0, 0, 1, 90001);
        chk("disable_peak1", dut_vec(), model_vec());

        cyc(1, 2, 32'h101, 0, 0);
        cyc(0, 0, 0, 0, 0);
        cyc(0, 0, 0, 1, 6000);
        chk("pre_reset_active", dut_vec(), model_vec());
        do_reset();
        chk("reset_mid", dut_vec(), 53'd0);
        cyc(0, 0, 0, 1, 6000);
        cyc(0, 0, 0, 1, 6000);
        chk("reset_regs", dut_vec(), model_vec());

        for (int n = 0; n < 3000; n++) begin
            if ($urandom_range(0, 499) == 0) begin
                do_reset();
                chk($sformatf("rand_reset[%0d]", n), dut_vec(), model_vec());
                continue;
            end
            s = $urandom_range(0, 99) < 8;
            a = 8'($urandom_range(0, 5));
            case (a)
                8'd0, 8'd1: d = $urandom_range(0, 1000);
                8'd2: d = {16'($urandom_range(0, 3)), 8'($urandom_range(0, 4)), 7'($urandom), $urandom_range(0, 9) != 0};
                default: d = $urandom;
            endcase
            st = $urandom_range(0, 99) < 70;
            p = $urandom_range(0, 19) == 0 ? $urandom : $urandom_range(0, 1100);
            cyc(s, a, d, st, p);
            chk($sformatf("rand[%0d]", n), dut_vec(), model_vec());
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
